// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data-cache controller.
// One-word lines. Misses and stores are sequenced to a multi-cycle memory
// through a req/ready handshake, and DC_Stall freezes the pipeline meanwhile.
// Optional build macro DCACHE_STATS_EN adds read-hit / read-miss / write
// event counters as extra output ports.
module dcache_ctrl #(
    parameter int bit_size = 32,
    parameter int INDEX_W  = 5,
    parameter int TAG_W    = bit_size - INDEX_W - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_MemRead,
    input  logic                MEM_MemWrite,
    input  logic [bit_size-1:0] MEM_addr,
    input  logic [bit_size-1:0] MEM_din,
    output logic [bit_size-1:0] MEM_dout,
    output logic                DC_Stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [bit_size-1:0] mem_addr,
    output logic [bit_size-1:0] mem_wdata,
    input  logic [bit_size-1:0] mem_rdata,
    input  logic                mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]         dc_hit_cnt,
    output logic [31:0]         dc_miss_cnt,
    output logic [31:0]         dc_wr_cnt
`endif
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WTHRU = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [bit_size-1:0]   data_q [LINES];
    logic [bit_size-1:0]   addr_q;
    logic [bit_size-1:0]   din_q;
    logic [bit_size-1:0]   ret_q;
    logic                  wr_hit_q;
    logic                  is_wr_q;

    logic [INDEX_W-1:0]    index_s;
    logic [TAG_W-1:0]      tag_s;
    logic                  hit_s;
    logic [INDEX_W-1:0]    lidx_s;
    logic [TAG_W-1:0]      ltag_s;
    logic                  fill_wr_s;
    logic                  thru_wr_s;
    logic                  latch_s;

    assign index_s   = MEM_addr[INDEX_W+1:2];
    assign tag_s     = MEM_addr[bit_size-1:INDEX_W+2];
    assign hit_s     = valid_q[index_s] && (tag_q[index_s] == tag_s);
    assign lidx_s    = addr_q[INDEX_W+1:2];
    assign ltag_s    = addr_q[bit_size-1:INDEX_W+2];
    // Storage writes are suppressed under reset so an abandoned fill leaves no trace.
    assign fill_wr_s = (state_q == FILL) && mem_ready && !rst;
    assign thru_wr_s = (state_q == WTHRU) && mem_ready && wr_hit_q && !rst;
    assign latch_s   = (state_q == IDLE) && (state_d != IDLE);

    // Next-state and combinational outputs; hits answer in the request cycle.
    always_comb begin
        state_d   = state_q;
        DC_Stall  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        MEM_dout  = '0;
        case (state_q)
            IDLE: begin
                if (MEM_MemWrite) begin
                    DC_Stall = 1'b1;
                    state_d  = WTHRU;
                end else if (MEM_MemRead) begin
                    if (hit_s) begin
                        MEM_dout = data_q[index_s];
                    end else begin
                        DC_Stall = 1'b1;
                        state_d  = FILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                DC_Stall = 1'b1;
                mem_read = 1'b1;
                mem_addr = addr_q & {{(bit_size-2){1'b1}}, 2'b00};
                if (mem_ready) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            WTHRU: begin
                DC_Stall  = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr_q & {{(bit_size-2){1'b1}}, 2'b00};
                mem_wdata = din_q;
                if (mem_ready) begin
                    state_d = DONE;
                end else begin
                    state_d = WTHRU;
                end
            end
            DONE: begin
                if (is_wr_q) begin
                    MEM_dout = '0;
                end else begin
                    MEM_dout = ret_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and valid bits; reset abandons any outstanding transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_wr_s) begin
                valid_q[lidx_s] <= 1'b1;
            end
        end
    end

    // Request capture on leaving IDLE and fill-data return register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            din_q    <= '0;
            wr_hit_q <= 1'b0;
            is_wr_q  <= 1'b0;
            ret_q    <= '0;
        end else begin
            if (latch_s) begin
                addr_q   <= MEM_addr;
                din_q    <= MEM_din;
                wr_hit_q <= MEM_MemWrite && hit_s;
                is_wr_q  <= MEM_MemWrite;
            end
            if (fill_wr_s) begin
                ret_q <= mem_rdata;
            end
        end
    end

    // Line tag/data storage; contents are qualified by valid_q so carry no reset.
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            tag_q[lidx_s]  <= ltag_s;
            data_q[lidx_s] <= mem_rdata;
        end else if (thru_wr_s) begin
            data_q[lidx_s] <= din_q;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wr_cnt_q;

    // Event counters, only counted on IDLE request cycles, wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            wr_cnt_q   <= 32'd0;
        end else if (state_q == IDLE) begin
            if (MEM_MemWrite) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else if (MEM_MemRead && hit_s) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else if (MEM_MemRead) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign dc_hit_cnt  = hit_cnt_q;
    assign dc_miss_cnt = miss_cnt_q;
    assign dc_wr_cnt   = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized
// traffic against a word-addressed backing memory and a line-occupancy model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_MemRead, MEM_MemWrite;
    logic [31:0] MEM_addr, MEM_din, MEM_dout;
    logic        DC_Stall, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0] dc_hit_cnt, dc_miss_cnt, dc_wr_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int n_hit  = 0;
    int n_miss = 0;
    int n_wr   = 0;

    logic [31:0] backing   [logic [29:0]];
    logic [29:0] line_word [int];

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_addr     (MEM_addr),
        .MEM_din      (MEM_din),
        .MEM_dout     (MEM_dout),
        .DC_Stall     (DC_Stall),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .dc_hit_cnt   (dc_hit_cnt),
        .dc_miss_cnt  (dc_miss_cnt),
        .dc_wr_cnt    (dc_wr_cnt)
`endif
    );

    function automatic logic [31:0] mem_val(input logic [29:0] w);
        if (!backing.exists(w)) begin
            backing[w] = $urandom;
        end
        return backing[w];
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[6:2]);
        return line_word.exists(idx) && (line_word[idx] == a[31:2]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        line_word.delete();
        n_hit  = 0;
        n_miss = 0;
        n_wr   = 0;
    endtask

    // One complete MEM-stage access including the IDLE cycle after it.
    task automatic do_access(input bit wr, input bit both, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat);
        logic [29:0] word;
        bit          exp_hit;
        int          stalls;
        word    = addr[31:2];
        exp_hit = !wr && model_hit(addr);
        MEM_MemWrite = wr;
        MEM_MemRead  = !wr || both;
        MEM_addr     = addr;
        MEM_din      = wdata;
        mem_ready    = 1'($urandom_range(0, 1));
        mem_rdata    = $urandom;
        @(negedge clk);
        if (exp_hit) begin
            n_hit++;
            checks++;
            if (DC_Stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL hit_ctl addr=%h got stall=%b rd=%b wr=%b exp 0/0/0", addr, DC_Stall, mem_read, mem_write);
            end
            checks++;
            if (MEM_dout !== mem_val(word)) begin
                errors++;
                $display("FAIL hit_data addr=%h got=%h exp=%h", addr, MEM_dout, mem_val(word));
            end
            tick();
        end else begin
            if (wr) n_wr++; else n_miss++;
            checks++;
            if (DC_Stall !== 1'b1) begin
                errors++;
                $display("FAIL req_stall addr=%h got=%b exp=1", addr, DC_Stall);
            end
            stalls = (DC_Stall === 1'b1) ? 1 : 0;
            tick();
            for (int i = 1; i <= lat; i++) begin
                mem_ready = (i == lat);
                mem_rdata = (i == lat) ? mem_val(word) : $urandom;
                @(negedge clk);
                if (DC_Stall === 1'b1) stalls++;
                checks++;
                if (mem_read !== !wr || mem_write !== wr || mem_addr !== {word, 2'b00}) begin
                    errors++;
                    $display("FAIL busy_req addr=%h cyc=%0d got rd=%b wr=%b maddr=%h exp rd=%b wr=%b maddr=%h",
                             addr, i, mem_read, mem_write, mem_addr, !wr, wr, {word, 2'b00});
                end
                if (wr) begin
                    checks++;
                    if (mem_wdata !== wdata) begin
                        errors++;
                        $display("FAIL wdata addr=%h got=%h exp=%h", addr, mem_wdata, wdata);
                    end
                end
                tick();
            end
            mem_ready = 1'b0;
            if (wr) backing[word] = wdata;
            else line_word[int'(addr[6:2])] = word;
            // DONE cycle: request still presented but must be ignored.
            @(negedge clk);
            checks++;
            if (DC_Stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL done_ctl addr=%h got stall=%b rd=%b wr=%b exp 0/0/0", addr, DC_Stall, mem_read, mem_write);
            end
            checks++;
            if (MEM_dout !== (wr ? 32'd0 : backing[word])) begin
                errors++;
                $display("FAIL done_data addr=%h got=%h exp=%h", addr, MEM_dout, wr ? 32'd0 : backing[word]);
            end
            checks++;
            if (stalls != lat + 1) begin
                errors++;
                $display("FAIL stall_len addr=%h got=%0d exp=%0d", addr, stalls, lat + 1);
            end
            tick();
        end
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        MEM_din      = $urandom;
        @(negedge clk);
        checks++;
        if (DC_Stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || MEM_dout !== 32'd0) begin
            errors++;
            $display("FAIL idle addr=%h got stall=%b rd=%b wr=%b dout=%h exp 0/0/0/0", addr, DC_Stall, mem_read, mem_write, MEM_dout);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        MEM_addr = 32'd0; MEM_din = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (DC_Stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || MEM_dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got stall=%b rd=%b wr=%b dout=%h exp 0/0/0/0", DC_Stall, mem_read, mem_write, MEM_dout);
        end
        tick();
    endtask

    task automatic test_read_miss_hit();
        backing[30'h10] = 32'hDEADBEEF;
        do_access(1'b0, 1'b0, 32'h0000_0040, 32'd0, 3);
        do_access(1'b0, 1'b0, 32'h0000_0040, 32'd0, 3);
    endtask

    task automatic test_conflict();
        do_access(1'b0, 1'b0, 32'h0000_00C0, 32'd0, 2);
        do_access(1'b0, 1'b0, 32'h0000_0040, 32'd0, 1);
        do_access(1'b0, 1'b0, 32'h0000_00C0, 32'd0, 4);
        do_access(1'b0, 1'b0, 32'h0000_0040, 32'd0, 2);
    endtask

    task automatic test_store_hit();
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 2);
        do_access(1'b0, 1'b0, 32'h0000_0043, 32'd0, 2);
    endtask

    task automatic test_store_miss();
        do_access(1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 2);
        do_access(1'b0, 1'b0, 32'h0000_0080, 32'd0, 3);
        do_access(1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_0F0F, 1);
        do_access(1'b0, 1'b0, 32'h0000_0080, 32'd0, 1);
    endtask

    task automatic test_reset_fill();
        test_reset();
        MEM_MemRead = 1'b1;
        MEM_addr    = 32'h0000_0040;
        tick();
        mem_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        MEM_MemRead = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || DC_Stall !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill got rd=%b stall=%b wr=%b exp 0/0/0", mem_read, DC_Stall, mem_write);
        end
        tick();
        do_access(1'b0, 1'b0, 32'h0000_0040, 32'd0, 2);
    endtask

    task automatic test_random();
        logic [24:0] tg;
        logic [4:0]  ix;
        logic [1:0]  lo;
        int          sel;
        for (int n = 0; n < 150; n++) begin
            tg  = 25'($urandom_range(0, 2));
            sel = $urandom_range(0, 3);
            ix  = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : (sel == 2) ? 5'd16 : 5'd31;
            lo  = 2'($urandom_range(0, 3));
            do_access($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
                      {tg, ix, lo}, $urandom, $urandom_range(1, 4));
        end
    endtask

    task automatic test_stats();
`ifdef DCACHE_STATS_EN
        checks++;
        if (dc_hit_cnt !== 32'(n_hit) || dc_miss_cnt !== 32'(n_miss) || dc_wr_cnt !== 32'(n_wr)) begin
            errors++;
            $display("FAIL stats got h=%0d m=%0d w=%0d exp h=%0d m=%0d w=%0d",
                     dc_hit_cnt, dc_miss_cnt, dc_wr_cnt, n_hit, n_miss, n_wr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_conflict();
        test_store_hit();
        test_store_miss();
        test_reset_fill();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data-cache controller in the MEM stage.
- It is the producer of DC_Stall, which the hazard detection unit uses to freeze PC, IF/ID, ID/EX, EX/M and M/WB.
- It serves MEM-stage loads and stores from one-word lines.
- It sequences misses and write-throughs to a multi-cycle data memory using a req/ready handshake.

Parameters:
- bit_size, 32, data and address width.
- INDEX_W, 5, index bits; number of lines = 2^INDEX_W.
- TAG_W, bit_size-INDEX_W-2, tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- MEM_MemRead  in  1  load request from the MEM stage.
- MEM_MemWrite  in  1  store request from the MEM stage.
- MEM_addr  in  bit_size  byte address; bits [1:0] ignored.
- MEM_din  in  bit_size  store data.
- MEM_dout  out  bit_size  load data.
- DC_Stall  out  1  pipeline freeze request.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_addr  out  bit_size  memory word address, with bits [1:0] forced to 0.
- mem_wdata  out  bit_size  memory write data.
- mem_rdata  in  bit_size  memory read data; valid when mem_ready=1.
- mem_ready  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split:
  - index = MEM_addr[INDEX_W+1:2]
  - tag = MEM_addr[bit_size-1:INDEX_W+2]
  - hit = valid[index] and tag_arr[index]==tag
- Storage: valid[], tag_arr[], data_arr[] registers. valid[] is cleared by reset. Tags and data are not reset.
- State machine: IDLE, FILL, WTHRU, DONE. Reset state is IDLE.
- IDLE, no request: DC_Stall=0, mem_read=0, mem_write=0, MEM_dout=0.
- IDLE, read hit: MEM_dout=data_arr[index] combinationally in the same cycle; DC_Stall=0; no state change.
- IDLE, read miss: DC_Stall=1 combinationally in the same cycle; next state FILL.
- IDLE, MEM_MemWrite=1 (hit or miss): DC_Stall=1 combinationally; next state WTHRU.
- Simultaneous MEM_MemRead and MEM_MemWrite: treated as a write.
- Requests are latched into internal registers on leaving IDLE: addr, din, and whether the write was a hit.
- FILL:
  - DC_Stall=1, mem_read=1, mem_addr=latched word address; hold until mem_ready.
  - On the mem_ready cycle: write data_arr/tag_arr with mem_rdata and the latched tag, set valid, capture mem_rdata into the return register, next state DONE.
- WTHRU:
  - DC_Stall=1, mem_write=1, mem_addr=latched address, mem_wdata=latched din; hold until mem_ready.
  - On mem_ready: if the latched write was a hit, update data_arr[index] to din; a miss does not allocate. Next state DONE.
- DONE (exactly one cycle):
  - DC_Stall=0; MEM_dout=return register on a read, 0 on a write.
  - mem_read=0, mem_write=0. Requests on MEM_* are ignored this cycle; the pipeline advances.
  - Next state IDLE.
- Latency:
  - Hit: 0 stall cycles.
  - Miss or store: DC_Stall high for (memory latency + 1) cycles, counted from the request cycle through the mem_ready cycle, then low in DONE.
- mem_ready outside FILL/WTHRU is ignored.
- mem_read and mem_write are never high together.
- Reset mid-FILL or mid-WTHRU: on the next edge go to IDLE with all valid bits cleared and mem_read, mem_write, DC_Stall=0; the outstanding transaction is abandoned.
- DC_Stall is a function of state and IDLE inputs only, never of mem_rdata.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, three extra 32-bit output ports are present:
  - dc_hit_cnt: increments on each IDLE read hit.
  - dc_miss_cnt: increments on each IDLE read miss.
  - dc_wr_cnt: increments on each IDLE write.
- The counters wrap at 2^32, are cleared by rst, and never increment in DONE.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Read miss after reset:
  - Stimulus: rst, then MEM_MemRead addr 0x40; memory returns 0xDEADBEEF with mem_ready 3 cycles after mem_read rises.
  - Response: DC_Stall=1 for 4 cycles; mem_read high 3 cycles with mem_addr=0x40; DONE cycle shows MEM_dout=0xDEADBEEF and DC_Stall=0.
- Read hit:
  - Stimulus: repeat a read of 0x40.
  - Response: same-cycle MEM_dout=0xDEADBEEF, DC_Stall=0, mem_read stays 0.
- Conflict miss:
  - Stimulus: read 0x40, then 0xC0 (same index 16 when INDEX_W=5, different tag), then 0x40 again.
  - Response: each access is a miss with a FILL.
- Store hit then load:
  - Stimulus: store 0x12345678 to 0x40 (cached), ready after 2 cycles; then load 0x40.
  - Response: mem_write high 2 cycles with mem_wdata=0x12345678; the following load hits and returns 0x12345678.
- Store miss then load:
  - Stimulus: store to 0x80 (not cached); then load 0x80.
  - Response: write-through occurs; the load misses (no allocate).
- Reset during FILL:
  - Stimulus: read miss to 0x40, assert rst during cycle 2 of FILL.
  - Response: next edge gives mem_read=0 and DC_Stall=0; a following read of 0x40 is a miss.
